// File: rtl/pio_in_edge_irq.sv
// Avalon-MM input PIO with a synchroniser, per-bit edge capture (write-1-to-clear)
// and a masked level interrupt on a 2-bit-address slave map.
module pio_in_edge_irq #(
    parameter int unsigned WIDTH       = 3,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned EDGE_TYPE   = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int unsigned CntW   = $clog2(SYNC_STAGES + 2);
    localparam logic [CntW-1:0] ArmCount = CntW'(SYNC_STAGES + 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] d1_q;
    logic [CntW-1:0]  arm_cnt_q, arm_cnt_d;
    logic             arm;
    logic [WIDTH-1:0] edge_raw;
    logic [WIDTH-1:0] edge_vec;
    logic [WIDTH-1:0] clr;
    logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
    logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
    logic [31:0]      rdata_mux;
    logic             wr_en;
    logic             unused_wdata;

    // Bits of writedata above WIDTH are architecturally ignored.
    assign unused_wdata = ^writedata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= in_port;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign data = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            d1_q <= '0;
        end else begin
            d1_q <= data;
        end
    end

    // Hold off capture until s[]/d1 have flushed their reset values.
    always_comb begin
        arm_cnt_d = arm_cnt_q;
        if (arm_cnt_q != ArmCount) begin
            arm_cnt_d = arm_cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            arm_cnt_q <= '0;
        end else begin
            arm_cnt_q <= arm_cnt_d;
        end
    end

    assign arm = (arm_cnt_q == ArmCount);

    generate
        if (EDGE_TYPE == 0) begin : g_rise
            assign edge_raw = data & ~d1_q;
        end else if (EDGE_TYPE == 1) begin : g_fall
            assign edge_raw = ~data & d1_q;
        end else begin : g_any
            assign edge_raw = data ^ d1_q;
        end
    endgenerate

    assign edge_vec = arm ? edge_raw : '0;
    assign wr_en    = chipselect & ~write_n;

    always_comb begin
        clr        = '0;
        irq_mask_d = irq_mask_q;
        if (wr_en && address == 2'd3) begin
            clr = writedata[WIDTH-1:0];
        end
        if (wr_en && address == 2'd2) begin
            irq_mask_d = writedata[WIDTH-1:0];
        end
        // A new edge wins over a same-cycle clear.
        edge_cap_d = edge_vec | (edge_cap_q & ~clr);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_cap_q <= '0;
            irq_mask_q <= '0;
        end else begin
            edge_cap_q <= edge_cap_d;
            irq_mask_q <= irq_mask_d;
        end
    end

    assign irq = |(edge_cap_q & irq_mask_q);

    always_comb begin
        rdata_mux = '0;
        unique case (address)
            2'd0:    rdata_mux[WIDTH-1:0] = data;
            2'd2:    rdata_mux[WIDTH-1:0] = irq_mask_q;
            2'd3:    rdata_mux[WIDTH-1:0] = edge_cap_q;
            default: rdata_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= rdata_mux;
        end
    end

endmodule

// File: tb/tb_pio_in_edge_irq.sv
// Self-checking bench: four PIO instances (rising, falling, any-edge, 32-bit) on a shared bus.
module tb_pio_in_edge_irq;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;

    logic [2:0]  in_r = '0, in_f = '0, in_a = '0;
    logic [31:0] in_w = '0;
    logic [31:0] rd_r, rd_f, rd_a, rd_w;
    logic        irq_r, irq_f, irq_a, irq_w;

    int checks = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } sb_item_t;

    sb_item_t sb_q[$];

    always #5 clk = ~clk;

    pio_in_edge_irq #(.WIDTH(3), .SYNC_STAGES(2), .EDGE_TYPE(0)) dut_r (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_r), .readdata(rd_r), .irq(irq_r)
    );
    pio_in_edge_irq #(.WIDTH(3), .SYNC_STAGES(2), .EDGE_TYPE(1)) dut_f (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_f), .readdata(rd_f), .irq(irq_f)
    );
    pio_in_edge_irq #(.WIDTH(3), .SYNC_STAGES(2), .EDGE_TYPE(2)) dut_a (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_a), .readdata(rd_a), .irq(irq_a)
    );
    pio_in_edge_irq #(.WIDTH(32), .SYNC_STAGES(2), .EDGE_TYPE(0)) dut_w (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_w), .readdata(rd_w), .irq(irq_w)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rd_sel(input int sel);
        case (sel)
            0:       return rd_r;
            1:       return rd_f;
            2:       return rd_a;
            default: return rd_w;
        endcase
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Expected value is queued as the address is driven; compared one edge later.
    task automatic bus_read(input int sel, input logic [1:0] a, input logic [31:0] exp,
                            input string tag);
        sb_item_t item;
        address = a;
        sb_q.push_back('{tag: tag, sel: sel, exp: exp});
        @(negedge clk);
        item = sb_q.pop_front();
        check_eq(item.tag, rd_sel(item.sel), item.exp);
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] v);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b0;
        writedata  = v;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    initial begin
        // Reset with inputs already high: no spurious capture.
        in_r = 3'b111;
        cycles(2);
        reset_n = 1'b1;
        cycles(2);
        check_eq("data_latency_r", rd_r, 32'h0);
        cycles(1);
        check_eq("data_after_3", rd_r, 32'h7);
        cycles(4);
        bus_write(2'd2, 32'h7);
        check_eq("irq_after_reset_high", {31'b0, irq_r}, 32'h0);
        bus_read(0, 2'd3, 32'h0, "ec_after_reset_high");
        bus_read(0, 2'd1, 32'h0, "reserved_r");

        // Rising edge 0->5 after arm.
        reset_n = 1'b0;
        in_r = 3'b000;
        cycles(1);
        reset_n = 1'b1;
        cycles(6);
        bus_write(2'd2, 32'h7);
        in_r = 3'b101;
        address = 2'd3;
        cycles(2);
        check_eq("irq_before_edge3", {31'b0, irq_r}, 32'h0);
        cycles(1);
        check_eq("irq_at_edge3", {31'b0, irq_r}, 32'h1);
        bus_read(0, 2'd3, 32'h5, "ec_rise5");
        bus_read(0, 2'd0, 32'h5, "data_5");
        bus_write(2'd3, 32'h1);
        check_eq("irq_after_clr1", {31'b0, irq_r}, 32'h1);
        bus_read(0, 2'd3, 32'h4, "ec_after_clr1");
        bus_write(2'd3, 32'h4);
        check_eq("irq_after_clr4", {31'b0, irq_r}, 32'h0);
        bus_read(0, 2'd3, 32'h0, "ec_after_clr4");

        // Mask control and width truncation of IRQMASK.
        in_r = 3'b100;
        cycles(4);
        in_r = 3'b101;
        cycles(4);
        check_eq("irq_bit0_set", {31'b0, irq_r}, 32'h1);
        bus_write(2'd2, 32'h0);
        check_eq("irq_mask_off", {31'b0, irq_r}, 32'h0);
        bus_read(0, 2'd2, 32'h0, "mask_rd_0");
        bus_write(2'd2, 32'hFFFF_FFFF);
        check_eq("irq_mask_on", {31'b0, irq_r}, 32'h1);
        bus_read(0, 2'd2, 32'h7, "mask_rd_trunc");

        // Clear coincident with a new rising edge: set wins.
        in_r = 3'b100;
        cycles(4);
        in_r = 3'b101;
        cycles(2);
        bus_write(2'd3, 32'h1);
        check_eq("irq_set_wins", {31'b0, irq_r}, 32'h1);
        bus_read(0, 2'd3, 32'h1, "ec_set_wins");
        bus_write(2'd3, 32'h1);
        check_eq("irq_plain_clr", {31'b0, irq_r}, 32'h0);
        in_r = 3'b100;
        cycles(4);
        in_r = 3'b101;
        cycles(4);
        check_eq("irq_reraise", {31'b0, irq_r}, 32'h1);

        // Asynchronous reset mid-operation, then re-arm.
        in_f = 3'b111;
        in_a = 3'b000;
        in_w = 32'hA5A5_0F0F;
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("irq_async_reset", {31'b0, irq_r}, 32'h0);
        check_eq("rd_async_reset", rd_r, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        cycles(8);
        bus_read(0, 2'd3, 32'h0, "ec_rearm_r");
        bus_read(1, 2'd3, 32'h0, "ec_rearm_f");

        // Falling and any-edge modes.
        in_f = 3'b010;
        cycles(4);
        bus_read(1, 2'd3, 32'h5, "ec_fall");
        in_a = 3'b010;
        cycles(4);
        bus_read(2, 2'd3, 32'h2, "ec_any_first");
        in_a = 3'b000;
        cycles(4);
        bus_read(2, 2'd3, 32'h2, "ec_any_second");

        // 32-bit instance: full-width data, ignored writes, mask readback.
        bus_read(3, 2'd0, 32'hA5A5_0F0F, "data_w");
        bus_read(3, 2'd1, 32'h0, "reserved_w");
        bus_write(2'd0, 32'h0);
        bus_write(2'd1, 32'hFFFF_FFFF);
        bus_read(3, 2'd0, 32'hA5A5_0F0F, "data_w_after_wr");
        bus_read(3, 2'd1, 32'h0, "reserved_w_after_wr");
        bus_write(2'd2, 32'hFFFF_FFFF);
        bus_read(3, 2'd2, 32'hFFFF_FFFF, "mask_w");
        bus_read(3, 2'd3, 32'h0, "ec_w");
        check_eq("irq_w", {31'b0, irq_w}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
